// File: rtl/led_activity_bank_pkg.sv
// led_activity_pkg: shared types and helpers for the LED activity bank.
//   chan_state_t : per-channel FSM state (IDLE / ON / GAP)
//   clog2        : ceil(log2(v)), never below 1 so counters always have a bit
package led_activity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } chan_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'(1) << r) < 64'(v)) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_activity_bank_if.sv
// Bus bundle for led_activity_bank.
//   in         : asynchronous activity inputs, one bit per channel
//   led_out    : per-channel stretched LED drive
//   led_any    : OR of led_out
//   rate_data  : per-channel event count of the last window, ch0 in LSBs
//   rate_valid : one-cycle strobe when rate_data updates
// master drives the inputs (board / bench), slave is the bank itself.
interface led_activity_bank_if #(
  parameter int NCH    = 4,
  parameter int RATE_W = 16
);
  logic [NCH-1:0]        in;
  logic [NCH-1:0]        led_out;
  logic                  led_any;
  logic [NCH*RATE_W-1:0] rate_data;
  logic                  rate_valid;

  modport master (output in, input led_out, led_any, rate_data, rate_valid);
  modport slave  (input in, output led_out, led_any, rate_data, rate_valid);
endinterface

// File: rtl/led_activity_bank_chan.sv
// led_stretch_chan: one activity channel.
//   clk, reset : clock, synchronous active-high reset
//   i_in       : asynchronous activity input
//   o_led      : registered stretched LED drive
//   o_edge     : synchronised rising-edge pulse (feeds the optional rate counter)
// Input is double-flopped (s0, s1), s2 is history; a rising edge starts an
// on-pulse of STRETCH cycles, followed by a forced GAP_CYCLES off-time so
// continuous activity blinks. Edges during the gap are remembered in r_pend.
module led_stretch_chan
  import led_activity_pkg::*;
#(
  parameter int STRETCH    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int RETRIGGER  = 0,
  parameter int CNT_W      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_led,
  output logic o_edge
);
  localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic             r_s0, r_s1, r_s2;
  logic             r_led, r_pend;
  logic [CNT_W-1:0] r_cnt;
  chan_state_t      r_state;
  logic             w_edge;

  assign w_edge = r_s1 & ~r_s2;
  assign o_edge = w_edge;
  assign o_led  = r_led;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_led   <= 1'b0;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_state <= IDLE;
    end else begin
      r_s0 <= i_in;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_state <= ON;
            r_cnt   <= ON_LD;
            r_led   <= 1'b1;
          end
        end
        ON: begin
          // Without retrigger an edge while lit is simply dropped.
          if (w_edge && (RETRIGGER != 0)) begin
            r_cnt <= ON_LD;
          end else if (r_cnt == '0) begin
            r_led  <= 1'b0;
            r_pend <= 1'b0;
            if (GAP_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_state <= GAP;
              r_cnt   <= GAP_LD;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_pend <= 1'b0;
            // An edge on the last gap cycle counts as pending too.
            if (r_pend || w_edge) begin
              r_state <= ON;
              r_cnt   <= ON_LD;
              r_led   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_edge) r_pend <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_led   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/led_activity_bank.sv
// led_activity_bank: NCH-channel LED activity indicator.
//   clk, reset : clock, synchronous active-high reset
//   bus        : led_activity_bank_if.slave (in, led_out, led_any,
//                rate_data, rate_valid)
// Optional feature: define LED_RATE_COUNT_EN to build per-channel edge-rate
// counters over a WINDOW-cycle window; otherwise rate_data/rate_valid are 0.
module led_activity_bank
  import led_activity_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int STRETCH    = 2400000,
  parameter int GAP_CYCLES = 1200000,
  parameter int RETRIGGER  = 0,
  parameter int WINDOW     = 48000000,
  parameter int RATE_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  led_activity_bank_if.slave  bus
);
  localparam int CNT_W = clog2((STRETCH > GAP_CYCLES) ? STRETCH : GAP_CYCLES);

  logic [NCH-1:0] w_led;
  logic [NCH-1:0] w_edge;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    led_stretch_chan #(
      .STRETCH   (STRETCH),
      .GAP_CYCLES(GAP_CYCLES),
      .RETRIGGER (RETRIGGER),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .i_in  (bus.in[g]),
      .o_led (w_led[g]),
      .o_edge(w_edge[g])
    );
  end

  assign bus.led_out = w_led;
  assign bus.led_any = |w_led;

`ifdef LED_RATE_COUNT_EN
  localparam int WIN_W = clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0]             r_win;
  logic [NCH-1:0][RATE_W-1:0]   r_cnt;
  logic [NCH-1:0][RATE_W-1:0]   r_rate;
  logic                         r_valid;
  logic [NCH-1:0][RATE_W-1:0]   w_inc;

  // Saturating increment; also used on the window's last cycle so that
  // an edge landing there is included in the published count.
  always_comb begin
    w_inc = r_cnt;
    for (int c = 0; c < NCH; c++)
      if (w_edge[c] && (r_cnt[c] != {RATE_W{1'b1}}))
        w_inc[c] = r_cnt[c] + RATE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win   <= '0;
      r_cnt   <= '0;
      r_rate  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_win == WIN_LAST) begin
        r_win   <= '0;
        r_rate  <= w_inc;
        r_cnt   <= '0;
        r_valid <= 1'b1;
      end else begin
        r_win <= r_win + WIN_W'(1);
        r_cnt <= w_inc;
      end
    end
  end

  assign bus.rate_data  = r_rate;
  assign bus.rate_valid = r_valid;
`else
  logic w_unused_edge;
  assign w_unused_edge  = ^w_edge;
  assign bus.rate_data  = '0;
  assign bus.rate_valid = 1'b0;
`endif
endmodule
